// File: rtl/la_trig_rle_capture.sv
// la_trig_rle_capture: triggered run-length-encoding logic-analyzer capture engine with an AXI-Stream record output
// Ports: axi_clk / la_reset_n (async, active-low) clock and reset; sig_in probe bus;
//        cfg_* enable, capture mask, trigger setup and packet length;
//        m_t* AXI-Stream master carrying {count, data} records;
//        st_state / st_overflow / st_level status (FSM state, sticky drop flag, FIFO occupancy).
module la_trig_rle_capture #(
  parameter int pSIG_WIDTH  = 24,
  parameter int pCNT_WIDTH  = 8,
  parameter int pFIFO_DEPTH = 16,
  parameter int pLEN_WIDTH  = 8
) (
  input  logic                           axi_clk,
  input  logic                           la_reset_n,
  input  logic [pSIG_WIDTH-1:0]          sig_in,
  input  logic                           cfg_enable,
  input  logic [pSIG_WIDTH-1:0]          cfg_mask,
  input  logic [1:0]                     cfg_trig_mode,
  input  logic [pSIG_WIDTH-1:0]          cfg_trig_val,
  input  logic [pSIG_WIDTH-1:0]          cfg_trig_mask,
  input  logic [pLEN_WIDTH-1:0]          cfg_pkt_len,
  output logic [pCNT_WIDTH+pSIG_WIDTH-1:0] m_tdata,
  output logic                           m_tvalid,
  output logic                           m_tlast,
  input  logic                           m_tready,
  output logic [1:0]                     st_state,
  output logic                           st_overflow,
  output logic [$clog2(pFIFO_DEPTH):0]   st_level
);
  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam int DW = pCNT_WIDTH + pSIG_WIDTH;
  localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [pSIG_WIDTH-1:0] s_q, s_prev_q, held_q, held_d;
  logic [pCNT_WIDTH-1:0] count_q, count_d;
  logic [AW:0] wptr_q, rptr_q, level;
  logic [pLEN_WIDTH-1:0] beat_q, beat_d, eff_len;
  logic overflow_q, overflow_d;
  logic [DW-1:0] mem_q [pFIFO_DEPTH];
  logic trig, fire, same, push, pop, full, wr;
  assign trig = cfg_trig_mode == 2'd1 ? ((s_q ^ cfg_trig_val) & cfg_trig_mask) == '0 :
                cfg_trig_mode == 2'd2 ? |((s_q ^ s_prev_q) & cfg_trig_mask) : 1'b1;
  assign fire = state_q == ARMED && cfg_enable && trig;
  assign level = wptr_q - rptr_q;
  assign full = level == (AW+1)'(pFIFO_DEPTH);
  assign m_tvalid = level != '0;
  assign m_tdata = mem_q[rptr_q[AW-1:0]];
  assign pop = m_tvalid & m_tready;
  // a pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign wr = push & (~full | pop);
  assign eff_len = cfg_pkt_len == '0 ? pLEN_WIDTH'(1) : cfg_pkt_len;
  assign m_tlast = m_tvalid & (beat_q >= eff_len | (state_q == FLUSH & level == (AW+1)'(1)));
  assign st_state = state_q;
  assign st_overflow = overflow_q;
  assign st_level = level;
  always_ff @(posedge axi_clk or negedge la_reset_n)
    if (!la_reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = cfg_enable ? ARMED : IDLE;
      ARMED:   state_d = !cfg_enable ? IDLE : trig ? CAPTURE : ARMED;
      CAPTURE: state_d = cfg_enable ? CAPTURE : FLUSH;
      FLUSH:   state_d = m_tvalid ? FLUSH : IDLE;
    endcase
  end
  always_comb begin
    same = s_q == held_q && count_q != CNT_MAX;
    // a disable in CAPTURE flushes the pending run regardless of the sample
    push = state_q == CAPTURE && !(cfg_enable && same);
    held_d = fire || (state_q == CAPTURE && cfg_enable && !same) ? s_q : held_q;
    count_d = state_q == CAPTURE && cfg_enable && same ? count_q + pCNT_WIDTH'(1) :
              fire || push ? pCNT_WIDTH'(1) : count_q;
    overflow_d = state_q == IDLE && cfg_enable ? 1'b0 : overflow_q | (push & full & ~pop);
    beat_d = !pop ? beat_q : m_tlast ? pLEN_WIDTH'(1) : beat_q + pLEN_WIDTH'(1);
  end
  always_ff @(posedge axi_clk or negedge la_reset_n)
    if (!la_reset_n) begin
      s_q        <= '0;
      s_prev_q   <= '0;
      held_q     <= '0;
      count_q    <= pCNT_WIDTH'(1);
      wptr_q     <= '0;
      rptr_q     <= '0;
      beat_q     <= pLEN_WIDTH'(1);
      overflow_q <= 1'b0;
    end else begin
      s_q        <= sig_in & cfg_mask;
      s_prev_q   <= s_q;
      held_q     <= held_d;
      count_q    <= count_d;
      wptr_q     <= wptr_q + (AW+1)'(wr);
      rptr_q     <= rptr_q + (AW+1)'(pop);
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  always_ff @(posedge axi_clk)
    if (wr) mem_q[wptr_q[AW-1:0]] <= {count_q, held_q};
endmodule
